// File: rtl/konami2_bus_master.sv
// Konami-2 (052001-style) bus initiator: turns one word request into an AS/RWb/ADDR cycle,
// completes it on active-low DTAC and aborts with err if DTAC never arrives.
module konami2_bus_master #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 64,
  parameter int SETUP_CYC = 1
) (
  input  logic              CLK12,
  input  logic              RESETn,
  input  logic              CE,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              AS,
  output logic              RWb,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOE,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DTAC
);

  localparam int WCNT_W = $clog2(TIMEOUT) + 1;
  localparam int SCNT_W = $clog2(SETUP_CYC) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t              state_q;
  logic                dtac_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [SCNT_W-1:0]   scnt_q;
  logic                ready_q;
  logic                done_q;
  logic                err_q;
  logic                as_q;
  logic                rwb_q;
  logic                doe_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   dout_q;
  logic [DATA_W-1:0]   rdata_q;

  // DTAC is sampled every clock, independent of CE, so decisions see a one-cycle-old value
  always_ff @(posedge CLK12 or negedge RESETn) begin
    if (!RESETn) begin
      dtac_q <= 1'b1;
    end else begin
      dtac_q <= DTAC;
    end
  end

  // Bus-cycle sequencer; everything except dtac_q freezes while CE=0
  always_ff @(posedge CLK12 or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= {WCNT_W{1'b0}};
      scnt_q  <= {SCNT_W{1'b0}};
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      as_q    <= 1'b1;
      rwb_q   <= 1'b1;
      doe_q   <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      dout_q  <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else if (CE) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            rwb_q   <= ~we;
            dout_q  <= wdata;
            doe_q   <= we;
            scnt_q  <= {SCNT_W{1'b0}};
            ready_q <= 1'b0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (scnt_q == SCNT_W'(SETUP_CYC - 1)) begin
            as_q    <= 1'b0;
            wcnt_q  <= {WCNT_W{1'b0}};
            state_q <= ST_STROBE;
          end else begin
            scnt_q <= scnt_q + SCNT_W'(1);
          end
        end
        ST_STROBE: begin
          // An acknowledge on the last wait cycle still completes the access
          if (!dtac_q) begin
            if (rwb_q) begin
              rdata_q <= DIN;
            end
            state_q <= ST_HOLD;
          end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
            as_q    <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_RELEASE;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        ST_HOLD: begin
          as_q    <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (dtac_q) begin
            doe_q   <= 1'b0;
            rwb_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          as_q    <= 1'b1;
          rwb_q   <= 1'b1;
          doe_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign done  = done_q;
  assign err   = err_q;
  assign AS    = as_q;
  assign RWb   = rwb_q;
  assign ADDR  = addr_q;
  assign DOUT  = dout_q;
  assign DOE   = doe_q;

endmodule

// File: tb/tb_konami2_bus_master.sv
// Directed bench for konami2_bus_master: read, write, timeout, CE gating, ack/timeout
// collision, back-to-back acceptance and asynchronous reset, with a simple DTAC responder.
module tb_konami2_bus_master;

  logic        CLK12  = 1'b0;
  logic        RESETn = 1'b0;
  logic        CE     = 1'b0;
  logic        req    = 1'b0;
  logic        we     = 1'b0;
  logic [15:0] addr   = 16'h0000;
  logic [7:0]  wdata  = 8'h00;
  logic [7:0]  DIN    = 8'h00;
  logic        DTAC   = 1'b1;
  logic        ready, done, err, AS, RWb, DOE;
  logic [7:0]  rdata, DOUT;
  logic [15:0] ADDR;

  int n_assert = 0;
  int n_fail   = 0;

  int         a_as_low, a_done_n, a_err_n, a_done_hi, a_first_as, a_cycles;
  bit         a_bus_ok;
  logic [7:0] a_rd;

  konami2_bus_master #(
    .ADDR_W(16), .DATA_W(8), .TIMEOUT(64), .SETUP_CYC(1)
  ) dut (
    .CLK12(CLK12), .RESETn(RESETn), .CE(CE), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .done(done), .err(err), .AS(AS),
    .RWb(RWb), .ADDR(ADDR), .DOUT(DOUT), .DOE(DOE), .DIN(DIN), .DTAC(DTAC)
  );

  always #5 CLK12 = ~CLK12;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access from IDLE. The responder pulls DTAC low once AS has been seen low on
  // ack_after CE-qualified samples (never if negative); in half mode CE toggles each clock
  // and the responder only moves DTAC in the clock just before a CE edge.
  task automatic do_access(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                           input int ack_after, input bit half, input bit hold_req,
                           input logic [15:0] a2);
    bit prev_ce, prev_done, prev_err, fin;
    int k, ce_cnt;
    a_as_low = 0; a_done_n = 0; a_err_n = 0; a_done_hi = 0; a_first_as = -1;
    a_cycles = 0; a_bus_ok = 1'b1; a_rd = 8'h00;
    k = 0; ce_cnt = 0; prev_done = 1'b0; prev_err = 1'b0; fin = 1'b0;
    we = wr; addr = a; wdata = wd; req = 1'b1; CE = 1'b1; DTAC = 1'b1;
    while (!fin && a_cycles < 400) begin
      prev_ce = CE;
      @(posedge CLK12); #1;
      a_cycles++;
      if (prev_ce) begin
        ce_cnt++;
        if (hold_req) addr = a2;
        else req = 1'b0;
      end
      if (prev_ce && AS === 1'b0) begin
        k++;
        a_as_low++;
        if (a_first_as < 0) a_first_as = ce_cnt;
      end
      if (done === 1'b1) begin
        a_done_hi++;
        a_rd = rdata;
      end
      if (done === 1'b1 && !prev_done) a_done_n++;
      if (err === 1'b1 && !prev_err) a_err_n++;
      prev_done = (done === 1'b1);
      prev_err  = (err === 1'b1);
      if (ready === 1'b0 && (ADDR !== a || RWb !== ~wr || DOE !== wr || DOUT !== wd))
        a_bus_ok = 1'b0;
      if (AS === 1'b1) DTAC = 1'b1;
      else if (ack_after >= 0 && k >= ack_after && (!half || !prev_ce)) DTAC = 1'b0;
      if (ready === 1'b1 && (a_done_n + a_err_n) > 0) fin = 1'b1;
      CE = half ? ~CE : 1'b1;
    end
    CE = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_AS", AS, 1); chk("rst_RWb", RWb, 1); chk("rst_ADDR", ADDR, 0);
    chk("rst_DOUT", DOUT, 0); chk("rst_DOE", DOE, 0); chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_ready", ready, 1);
    @(posedge CLK12); #1;
    RESETn = 1'b1; CE = 1'b1;
    @(posedge CLK12); #1;

    // Read with acknowledge
    DIN = 8'hC3;
    do_access(1'b0, 16'h5A10, 8'h11, 1, 1'b0, 1'b0, 16'h0000);
    chk("rd_budget", a_cycles < 400, 1);
    chk("rd_as_low", a_as_low, 3); chk("rd_done_n", a_done_n, 1);
    chk("rd_done_hi", a_done_hi, 1); chk("rd_err_n", a_err_n, 0);
    chk("rd_data", a_rd, 8'hC3); chk("rd_bus", a_bus_ok, 1);
    chk("rd_first_as", a_first_as, 2);
    chk("rd_idle_rwb", RWb, 1); chk("rd_idle_doe", DOE, 0); chk("rd_rdata_hold", rdata, 8'hC3);

    // Write with acknowledge
    DIN = 8'hFF;
    do_access(1'b1, 16'h7C08, 8'h42, 2, 1'b0, 1'b0, 16'h0000);
    chk("wr_budget", a_cycles < 400, 1);
    chk("wr_as_low", a_as_low, 4); chk("wr_done_n", a_done_n, 1); chk("wr_err_n", a_err_n, 0);
    chk("wr_bus", a_bus_ok, 1); chk("wr_first_as", a_first_as, 2);
    chk("wr_idle_doe", DOE, 0); chk("wr_idle_rwb", RWb, 1); chk("wr_idle_addr", ADDR, 16'h7C08);
    chk("wr_rdata_keep", rdata, 8'hC3);

    // Timeout: DTAC never asserted
    DIN = 8'h99;
    do_access(1'b0, 16'h1234, 8'h00, -1, 1'b0, 1'b0, 16'h0000);
    chk("to_budget", a_cycles < 400, 1);
    chk("to_as_low", a_as_low, 64); chk("to_err_n", a_err_n, 1); chk("to_done_n", a_done_n, 0);
    chk("to_AS", AS, 1); chk("to_rdata_keep", rdata, 8'hC3);

    // Acknowledge one cycle too late still times out
    do_access(1'b0, 16'h1235, 8'h00, 64, 1'b0, 1'b0, 16'h0000);
    chk("late_as_low", a_as_low, 64); chk("late_err_n", a_err_n, 1); chk("late_done_n", a_done_n, 0);

    // CE every second clock
    DIN = 8'h3C;
    do_access(1'b0, 16'h2468, 8'h00, 1, 1'b1, 1'b0, 16'h0000);
    chk("ce_budget", a_cycles < 400, 1);
    chk("ce_as_low", a_as_low, 3); chk("ce_done_n", a_done_n, 1); chk("ce_done_hi", a_done_hi, 2);
    chk("ce_err_n", a_err_n, 0); chk("ce_data", a_rd, 8'h3C); chk("ce_bus", a_bus_ok, 1);

    // Acknowledge on the last wait cycle wins; req held through the access
    DIN = 8'h77;
    do_access(1'b0, 16'h4000, 8'h00, 63, 1'b0, 1'b1, 16'h4001);
    chk("col_as_low", a_as_low, 65); chk("col_done_n", a_done_n, 1); chk("col_err_n", a_err_n, 0);
    chk("col_data", a_rd, 8'h77); chk("col_busy_ignored", a_bus_ok, 1);
    we = 1'b1; wdata = 8'hA5;
    @(posedge CLK12); #1;
    req = 1'b0;
    chk("b2b_ready", ready, 0); chk("b2b_addr", ADDR, 16'h4001);
    chk("b2b_doe", DOE, 1); chk("b2b_rwb", RWb, 0); chk("b2b_dout", DOUT, 8'hA5);
    @(posedge CLK12); #1;
    chk("b2b_as_low", AS, 0);

    // Asynchronous reset in STROBE
    #2 RESETn = 1'b0;
    #1;
    chk("arst_AS", AS, 1); chk("arst_DOE", DOE, 0); chk("arst_ready", ready, 1);
    chk("arst_done", done, 0); chk("arst_err", err, 0); chk("arst_RWb", RWb, 1);
    @(posedge CLK12); #1;
    RESETn = 1'b1;
    @(posedge CLK12); #1;
    chk("post_rst_ready", ready, 1); chk("post_rst_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
